frame_scanner: RTL
==================

# frame_scanner

Parametrised raster reader between the frame buffer and the pixel filter chain (gray → gaussian → sobel → canny). On a start pulse it issues one linear read per pixel of an H_RES × V_RES frame. It re-aligns the returned RAM data with data-enable and sync markers. It also supports consumer stall, programmable inter-line blanking for line-buffer filters, abort, and a frame-done handshake. It generalises the fixed 170×240 / 24-bit / 1-cycle-latency reader to arbitrary geometry, pixel width and RAM latency.

## Interface
- H_RES, 170: pixels per line (≥2)
- V_RES, 240: lines per frame (≥1)
- DATA_W, 24: pixel word width
- RD_LATENCY, 1: RAM read latency in cycles (1..4)
- HBLANK, 0: idle cycles inserted between lines (0..255; none after the last line)
- ADDR_W, $clog2(H_RES*V_RES): derived, not overridden

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; all state and outputs cleared immediately
- start_read  in  1  one-cycle request to scan a frame
- i_abort  in  1  synchronous; ends the scan and flushes the pipeline
- i_stall  in  1  consumer back-pressure; holds read issue
- rd_en  out  1  read strobe to RAM
- rd_addr  out  ADDR_W  linear pixel address, y*H_RES+x
- rd_data  in  DATA_W  RAM output, valid RD_LATENCY cycles after rd_en
- o_de  out  1  output pixel valid
- o_data  out  DATA_W  rd_data when o_de, else 0
- o_vsync  out  1  with o_de on pixel (0,0)
- o_hsync  out  1  with o_de on x==0 of every line
- o_eof  out  1  with o_de on the last pixel
- busy  out  1  scan in progress
- frame_done  out  1  one-cycle completion pulse

## Operation
- States:
  - IDLE: start_read → SCAN.
  - SCAN: x==H_RES-1 issued → HBLANK (HBLANK>0 and not last line), next line (HBLANK==0), or DRAIN (last line).
  - HBLANK: after HBLANK cycles → SCAN.
  - DRAIN: after RD_LATENCY cycles → DONE.
  - DONE: one cycle → IDLE.
- SCAN issues rd_en=1 each cycle unless i_stall. When stalled, rd_en=0 and x, y and the address hold.
- The address is an incrementing ADDR_W counter with no multiplier. x wraps at H_RES-1, y wraps at V_RES-1. rd_addr=0 outside SCAN/HBLANK. It holds the last issued value during HBLANK.
- The HBLANK counter runs regardless of i_stall.
- rd_en, first-pixel, line-start and last-pixel flags pass through an RD_LATENCY-deep shift register, which produces o_de, o_vsync, o_hsync and o_eof. o_data is combinational: rd_data gated by o_de.
- i_stall affects issue only. Up to RD_LATENCY beats already in flight still appear on o_de, and the consumer absorbs them.
- start_read outside IDLE is ignored (see Configuration).
- i_abort in any non-IDLE state:
  - → IDLE on the next edge.
  - Shift register cleared, so o_de=0 from the next cycle.
  - No frame_done is produced.
- i_abort has priority over start_read in the same cycle.
- Reset mid-frame gives the same result as abort, asynchronously.

## Timing
- Reset value of every output is 0. State is IDLE.
- start_read is sampled at edge n. State is SCAN and rd_en=1 with rd_addr=0 in cycle n+1.
- The first o_de (with o_vsync and o_hsync) is in cycle n+1+RD_LATENCY.
- busy is high from cycle n+1 through the cycle carrying o_eof.
- frame_done is high for exactly one cycle, the cycle after o_eof. busy=0 in that cycle.
- A new start_read is accepted in the frame_done cycle. The next frame's rd_en follows one cycle later.
- Unstalled frame length, start to frame_done: H_RES*V_RES + HBLANK*(V_RES-1) + RD_LATENCY + 1 cycles.
- Stall cycles add 1:1 to that length.

## Configuration
- FRAME_SCANNER_REPEAT_EN defined:
  - start_read during busy sets a pending flag, which saturates at one request.
  - On DONE, the block goes directly to SCAN with rd_addr=0 in the cycle after frame_done. frame_done still pulses.
  - i_abort and reset clear the pending flag.
- Undefined: start_read is ignored while not IDLE, and no pending logic is present.

## Test plan
- Bench parameters are H_RES=4, V_RES=3, RD_LATENCY=2, HBLANK=1, with the RAM model returning data = address.
- Basic frame:
  - Stimulus: start_read at edge 0.
  - rd_en in cycles 1-4, 6-9 and 11-14, with gaps at 5 and 10.
  - o_de cycles 3-6, 8-11 and 13-16, with o_data 0..11.
  - o_vsync at cycle 3. o_hsync at cycles 3, 8 and 13. o_eof at cycle 16.
  - frame_done at cycle 17. busy high in cycles 1-16.
- Stall: i_stall high in cycles 2-3.
  - rd_addr holds 1 and rd_en=0 in cycles 2-3.
  - Up to 2 beats already in flight still reach o_de.
  - frame_done moves to cycle 19. Data order stays 0..11 with no duplicates.
- Abort: i_abort at cycle 7.
  - IDLE at cycle 8, with o_de=0 and rd_addr=0 from cycle 8.
  - No frame_done. A start_read at cycle 10 restarts at address 0.
- Async reset at cycle 9, asserted between clock edges: all outputs are 0 immediately. After release, start_read gives a clean frame.
- Repeat macro, with start_read at cycles 0 and 5:
  - Defined: frame_done at 17, second frame rd_addr=0 at 18.
  - Undefined: only one frame.
- Geometry sweep at defaults (170×240, RD_LATENCY=1, HBLANK=0):
  - 40800 o_de beats, with addresses 0..40799 in order.
  - frame_done exactly 40802 cycles after start_read.

Source files
------------

// File: rtl/frame_scanner.sv
// frame_scanner: raster reader that issues one linear RAM read per pixel and re-aligns the returned
// data with DE/sync markers. Define FRAME_SCANNER_REPEAT_EN to queue a start_read that arrives mid-scan.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for start_read
//   SCAN    | issuing reads, one per unstalled cycle
//   HBLANK  | idle gap between lines, rd_addr holds last issued address
//   DRAIN   | last read issued, waiting RD_LATENCY cycles for it to return
//   DONE    | one-cycle frame_done pulse
module frame_scanner #(
    parameter int H_RES      = 170,
    parameter int V_RES      = 240,
    parameter int DATA_W     = 24,
    parameter int RD_LATENCY = 1,
    parameter int HBLANK     = 0,
    localparam int ADDR_W    = $clog2(H_RES * V_RES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_read,
    input  logic              i_abort,
    input  logic              i_stall,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              o_de,
    output logic [DATA_W-1:0] o_data,
    output logic              o_vsync,
    output logic              o_hsync,
    output logic              o_eof,
    output logic              busy,
    output logic              frame_done
);

    localparam int XW = $clog2(H_RES + 1);
    localparam int YW = $clog2(V_RES + 1);
    localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_HBLANK,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [XW-1:0]       x_q, x_d;
    logic [YW-1:0]       y_q, y_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [RD_LATENCY-1:0] de_q, sof_q, sol_q, eof_q;
    logic                issue;
    logic                line_end;
    logic                last_line;
    logic                restart;

`ifdef FRAME_SCANNER_REPEAT_EN
    logic pend_q, pend_d;
    assign restart = start_read || pend_q;
`else
    assign restart = start_read;
`endif

    assign issue     = (state_q == ST_SCAN) && !i_stall;
    assign line_end  = (x_q == X_LAST);
    assign last_line = (y_q == Y_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
`ifdef FRAME_SCANNER_REPEAT_EN
            pend_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
`ifdef FRAME_SCANNER_REPEAT_EN
            pend_q  <= pend_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
`ifdef FRAME_SCANNER_REPEAT_EN
        pend_d  = pend_q;
        if (start_read && (state_q == ST_SCAN || state_q == ST_HBLANK || state_q == ST_DRAIN)) begin
            pend_d = 1'b1;
        end
`endif
        if (i_abort) begin
            state_d = ST_IDLE;
            x_d     = '0;
            y_d     = '0;
            addr_d  = '0;
            cnt_d   = '0;
`ifdef FRAME_SCANNER_REPEAT_EN
            pend_d  = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_read) begin
                        state_d = ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (issue) begin
                        if (!line_end) begin
                            x_d    = x_q + 1'b1;
                            addr_d = addr_q + 1'b1;
                        end else if (last_line) begin
                            // Coordinates and address return to 0 so the next frame starts clean.
                            state_d = ST_DRAIN;
                            cnt_d   = 8'(RD_LATENCY - 1);
                            x_d     = '0;
                            y_d     = '0;
                            addr_d  = '0;
                        end else if (HBLANK > 0) begin
                            state_d = ST_HBLANK;
                            cnt_d   = 8'(HBLANK - 1);
                            x_d     = '0;
                        end else begin
                            x_d    = '0;
                            y_d    = y_q + 1'b1;
                            addr_d = addr_q + 1'b1;
                        end
                    end
                end
                ST_HBLANK: begin
                    if (cnt_q == 8'd0) begin
                        state_d = ST_SCAN;
                        y_d     = y_q + 1'b1;
                        addr_d  = addr_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_q == 8'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                ST_DONE: begin
                    if (restart) begin
                        state_d = ST_SCAN;
`ifdef FRAME_SCANNER_REPEAT_EN
                        pend_d  = 1'b0;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Markers travel alongside the read strobe so they line up with the returned RAM word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            de_q  <= '0;
            sof_q <= '0;
            sol_q <= '0;
            eof_q <= '0;
        end else if (i_abort) begin
            de_q  <= '0;
            sof_q <= '0;
            sol_q <= '0;
            eof_q <= '0;
        end else begin
            de_q[0]  <= issue;
            sof_q[0] <= issue && (x_q == '0) && (y_q == '0);
            sol_q[0] <= issue && (x_q == '0);
            eof_q[0] <= issue && line_end && last_line;
            for (int i = 1; i < RD_LATENCY; i++) begin
                de_q[i]  <= de_q[i-1];
                sof_q[i] <= sof_q[i-1];
                sol_q[i] <= sol_q[i-1];
                eof_q[i] <= eof_q[i-1];
            end
        end
    end

    always_comb begin
        rd_en      = issue;
        rd_addr    = '0;
        if (state_q == ST_SCAN || state_q == ST_HBLANK) begin
            rd_addr = addr_q;
        end
        o_de       = de_q[RD_LATENCY-1];
        o_data     = de_q[RD_LATENCY-1] ? rd_data : '0;
        o_vsync    = sof_q[RD_LATENCY-1];
        o_hsync    = sol_q[RD_LATENCY-1];
        o_eof      = eof_q[RD_LATENCY-1];
        busy       = (state_q == ST_SCAN) || (state_q == ST_HBLANK) || (state_q == ST_DRAIN);
        frame_done = (state_q == ST_DONE);
    end

endmodule
